// File: rtl/fft_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fft_reorder_buffer
// Description : Ping-pong reorder buffer that turns bit-reversed SDF FFT output
//               into natural bin order, with bin index and end-of-frame marker.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_reorder_buffer #(
  parameter  int N     = 64,
  parameter  int WIDTH = 16,
  localparam int LOG_N = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_di_en,
  input  logic [WIDTH-1:0] i_di_re,
  input  logic [WIDTH-1:0] i_di_im,
  output logic             o_do_en,
  output logic [WIDTH-1:0] o_do_re,
  output logic [WIDTH-1:0] o_do_im,
  output logic [LOG_N-1:0] o_do_idx,
  output logic             o_do_last
);

  localparam logic [LOG_N-1:0] c_LAST = LOG_N'(N - 1);

  typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} t_state;

  function automatic logic [LOG_N-1:0] f_bitrev(input logic [LOG_N-1:0] a);
    logic [LOG_N-1:0] r;
    for (int i = 0; i < LOG_N; i++) r[i] = a[LOG_N-1-i];
    return r;
  endfunction

  logic [2*WIDTH-1:0] r_mem [0:2*N-1];

  logic [LOG_N-1:0]   r_wr_count;
  logic               r_wr_bank;
  logic [1:0]         r_full;
  t_state             r_state;
  logic [LOG_N-1:0]   r_rd_addr;
  logic               r_rd_bank;

  logic               w_wr_done;
  logic               w_rd_done;
  logic [1:0]         w_full_set;
  logic [1:0]         w_full_clr;
  logic [2*WIDTH-1:0] w_rd_data;

  assign w_wr_done  = i_di_en && (r_wr_count == c_LAST);
  assign w_rd_done  = (r_state == S_READ) && (r_rd_addr == c_LAST);
  // Writer and reader always address different banks when both finish together
  assign w_full_set = {r_wr_bank, ~r_wr_bank} & {2{w_wr_done}};
  assign w_full_clr = {r_rd_bank, ~r_rd_bank} & {2{w_rd_done}};
  assign w_rd_data  = r_mem[{r_rd_bank, r_rd_addr}];

  always_ff @(posedge clock) begin
    if (i_di_en) r_mem[{r_wr_bank, f_bitrev(r_wr_count)}] <= {i_di_re, i_di_im};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_count <= '0;
      r_wr_bank  <= 1'b0;
      r_full     <= 2'b00;
      r_state    <= S_IDLE;
      r_rd_addr  <= '0;
      r_rd_bank  <= 1'b0;
      o_do_en    <= 1'b0;
      o_do_last  <= 1'b0;
      o_do_re    <= '0;
      o_do_im    <= '0;
      o_do_idx   <= '0;
    end else begin
      // A dropped di_en restarts the frame, discarding any partial burst
      if (i_di_en) r_wr_count <= r_wr_count + 1'b1;
      else         r_wr_count <= '0;
      if (w_wr_done) r_wr_bank <= ~r_wr_bank;

      r_full <= (r_full & ~w_full_clr) | w_full_set;

      case (r_state)
        S_IDLE: begin
          o_do_en   <= 1'b0;
          o_do_last <= 1'b0;
          if (r_full[r_rd_bank]) begin
            r_state   <= S_READ;
            r_rd_addr <= '0;
          end
        end
        S_READ: begin
          o_do_en   <= 1'b1;
          o_do_last <= (r_rd_addr == c_LAST);
          o_do_re   <= w_rd_data[2*WIDTH-1:WIDTH];
          o_do_im   <= w_rd_data[WIDTH-1:0];
          o_do_idx  <= r_rd_addr;
          if (r_rd_addr == c_LAST) begin
            r_rd_bank <= ~r_rd_bank;
            r_rd_addr <= '0;
            if (!r_full[~r_rd_bank]) r_state <= S_IDLE;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          o_do_en   <= 1'b0;
          o_do_last <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
